// File: rtl/arbitro_paralelo_serial.sv
// Shares one paralelo_serial lane among four byte requesters: COM training
// after reset, then round-robin grants with a bounded burst per requester.
module arbitro_paralelo_serial #(
  parameter int unsigned SYNC_LEN  = 4,
  parameter int unsigned MAX_BURST = 2,
  parameter logic [7:0]  COM       = 8'hBC
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [3:0]  valid_req,
  input  logic [31:0] data_req,
  input  logic        pause,
  output logic [3:0]  ready_req,
  output logic        valid_out,
  output logic [7:0]  data_out,
  output logic [1:0]  grant,
  output logic        link_up
);

  localparam int unsigned SYNC_W  = 4;
  localparam int unsigned BURST_W = 3;

  typedef enum logic {TRAIN = 1'b0, ACTIVE = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [SYNC_W-1:0]    sync_cnt_q, sync_cnt_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic                 bubble_q, bubble_d;
  logic [1:0]           grant_d;
  logic                 valid_out_d;
  logic [7:0]           data_out_d;
  logic                 link_up_d;
  logic                 accept_c;
  logic                 transfer_c;
  logic [1:0]           next_grant_c;
  logic [1:0]           cand_c;
  logic                 found_c;

  // State and registered outputs
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q     <= TRAIN;
      sync_cnt_q  <= '0;
      burst_cnt_q <= '0;
      bubble_q    <= 1'b0;
      grant       <= '0;
      valid_out   <= 1'b0;
      data_out    <= COM;
      link_up     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      bubble_q    <= bubble_d;
      grant       <= grant_d;
      valid_out   <= valid_out_d;
      data_out    <= data_out_d;
      link_up     <= link_up_d;
    end
  end

  // Training countdown; ACTIVE is terminal until reset
  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    case (state_q)
      TRAIN: begin
        sync_cnt_d = sync_cnt_q + SYNC_W'(1);
        if (sync_cnt_q == SYNC_W'(SYNC_LEN - 1)) state_d = ACTIVE;
      end
      default: ;
    endcase
  end

  // Accept, lane data and round-robin arbitration
  always_comb begin
    accept_c     = (state_q == ACTIVE) && !pause && !bubble_q;
    ready_req    = accept_c ? (4'b0001 << grant) : 4'b0000;
    transfer_c   = accept_c && valid_req[grant];
    next_grant_c = grant;
    cand_c       = grant;
    found_c      = 1'b0;
    // First valid requester after the current grantee, cyclically
    for (int k = 1; k < 4; k++) begin
      cand_c = grant + 2'(k);
      if (!found_c && valid_req[cand_c]) begin
        next_grant_c = cand_c;
        found_c      = 1'b1;
      end
    end

    grant_d     = grant;
    burst_cnt_d = burst_cnt_q;
    bubble_d    = bubble_q;
    valid_out_d = transfer_c;
    data_out_d  = transfer_c ? data_req[8*grant +: 8] : COM;
    link_up_d   = (state_d == ACTIVE);

    // A burst-ending transfer re-arbitrates and inserts one idle slot
    if (state_q == ACTIVE && !pause) begin
      if (bubble_q) begin
        bubble_d = 1'b0;
      end else if (transfer_c && burst_cnt_q != BURST_W'(MAX_BURST - 1)) begin
        burst_cnt_d = burst_cnt_q + BURST_W'(1);
      end else begin
        grant_d     = next_grant_c;
        burst_cnt_d = '0;
        bubble_d    = transfer_c;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_paralelo_serial.sv
// Directed bench for arbitro_paralelo_serial with hand-computed expectations.
module tb_arbitro_paralelo_serial;

  localparam logic [7:0] COM = 8'hBC;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [3:0]  valid_req;
  logic [31:0] data_req;
  logic        pause;
  logic [3:0]  ready_req;
  logic        valid_out;
  logic [7:0]  data_out;
  logic [1:0]  grant;
  logic        link_up;

  int checks   = 0;
  int failures = 0;

  arbitro_paralelo_serial dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .valid_req (valid_req),
    .data_req  (data_req),
    .pause     (pause),
    .ready_req (ready_req),
    .valid_out (valid_out),
    .data_out  (data_out),
    .grant     (grant),
    .link_up   (link_up)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, check lane invariants
  task automatic tick();
    @(posedge clk_4f);
    #1;
    chk("inv_idle_com", 32'(valid_out == 1'b0 ? data_out == COM : 1'b1), 32'd1);
    chk("inv_link_valid", 32'(link_up == 1'b0 ? valid_out == 1'b0 : 1'b1), 32'd1);
    chk("inv_onehot", 32'($countones(ready_req) <= 1), 32'd1);
  endtask

  logic [7:0] k [4];
  logic [3:0] acc;
  logic [7:0] exp_d [14] = '{8'h00, 8'h01, 8'hBC, 8'h10, 8'h11, 8'hBC, 8'h20,
                             8'h21, 8'hBC, 8'h30, 8'h31, 8'hBC, 8'h02, 8'h03};
  logic [1:0] exp_g [14] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                             2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};

  initial begin
    reset     = 1'b0;
    valid_req = 4'b0000;
    data_req  = 32'h0;
    pause     = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'(COM));
    chk("rst_link", 32'(link_up), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(ready_req), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Training: link_up rises on the 4th edge after release
    for (int i = 1; i <= 4; i++) begin
      chk("train_ready", 32'(ready_req), 32'd0);
      tick();
      chk("train_link", 32'(link_up), 32'(i == 4));
      chk("train_valid", 32'(valid_out), 32'd0);
      chk("train_data", 32'(data_out), 32'(COM));
    end
    chk("idle_ready", 32'(ready_req), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_valid", 32'(valid_out), 32'd0);
      chk("idle_data", 32'(data_out), 32'(COM));
      chk("idle_grant", 32'(grant), 32'd0);
    end

    // Requester 0 alone: FF, EE, bubble, DD, AA, bubble
    valid_req = 4'b0001;
    data_req  = 32'h0000_00FF;
    #1;
    tick(); chk("r0_b1", 32'(data_out), 32'hFF); chk("r0_v1", 32'(valid_out), 32'd1);
    data_req = 32'h0000_00EE;
    tick(); chk("r0_b2", 32'(data_out), 32'hEE); chk("r0_g2", 32'(grant), 32'd0);
    chk("r0_bubble_ready", 32'(ready_req), 32'd0);
    data_req = 32'h0000_00DD;
    tick(); chk("r0_b3", 32'(data_out), 32'(COM)); chk("r0_v3", 32'(valid_out), 32'd0);
    tick(); chk("r0_b4", 32'(data_out), 32'hDD);
    data_req = 32'h0000_00AA;
    tick(); chk("r0_b5", 32'(data_out), 32'hAA);
    valid_req = 4'b0000;
    tick(); chk("r0_b6", 32'(data_out), 32'(COM)); chk("r0_g6", 32'(grant), 32'd0);

    // All four requesters: round-robin with one idle slot per switch
    for (int i = 0; i < 4; i++) k[i] = 8'h00;
    valid_req = 4'b1111;
    for (int i = 0; i < 4; i++) data_req[8*i +: 8] = 8'(16 * i) + k[i];
    #1;
    for (int e = 0; e < 14; e++) begin
      acc = ready_req;
      tick();
      for (int i = 0; i < 4; i++) if (acc[i]) k[i] = k[i] + 8'h01;
      for (int i = 0; i < 4; i++) data_req[8*i +: 8] = 8'(16 * i) + k[i];
      chk("rr_data", 32'(data_out), 32'(exp_d[e]));
      chk("rr_valid", 32'(valid_out), 32'(exp_d[e] != COM));
      chk("rr_grant", 32'(grant), 32'(exp_g[e]));
      #1;
    end

    // Pause with grant=1 mid-burst
    valid_req = 4'b0010;
    #1;
    tick(); chk("p_bubble", 32'(valid_out), 32'd0); chk("p_g0", 32'(grant), 32'd1);
    tick(); chk("p_first", 32'(data_out), 32'h12); chk("p_g1", 32'(grant), 32'd1);
    pause     = 1'b1;
    valid_req = 4'b0110;
    data_req[15:8]  = 8'h13;
    data_req[23:16] = 8'h22;
    #1;
    chk("p_ready", 32'(ready_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("p_idle", 32'(data_out), 32'(COM));
      chk("p_hold", 32'(grant), 32'd1);
    end
    pause = 1'b0;
    #1;
    chk("p_release_ready", 32'(ready_req), 32'h2);
    tick(); chk("p_last", 32'(data_out), 32'h13); chk("p_rot", 32'(grant), 32'd2);
    valid_req = 4'b0100;
    tick(); chk("p_rot_bubble", 32'(valid_out), 32'd0);
    tick(); chk("p_r2", 32'(data_out), 32'h22); chk("p_r2_g", 32'(grant), 32'd2);

    // Reset mid-burst: immediate drop, byte discarded, training repeats
    data_req[23:16] = 8'h23;
    #1;
    chk("mr_ready_pre", 32'(ready_req), 32'h4);
    reset = 1'b1;
    #1;
    chk("mr_valid", 32'(valid_out), 32'd0);
    chk("mr_link", 32'(link_up), 32'd0);
    chk("mr_data", 32'(data_out), 32'(COM));
    chk("mr_ready", 32'(ready_req), 32'd0);
    tick();
    reset = 1'b0;
    pause = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("mr_train_ready", 32'(ready_req), 32'd0);
      tick();
      if (i == 2) pause = 1'b0;
      chk("mr_train_link", 32'(link_up), 32'(i == 4));
      chk("mr_train_valid", 32'(valid_out), 32'd0);
    end
    chk("mr_grant", 32'(grant), 32'd0);
    chk("mr_ready_after", 32'(ready_req), 32'h1);

    // Requester 2 alone, valid toggling 1,0,1
    tick(); chk("t2_regrant", 32'(valid_out), 32'd0); chk("t2_g", 32'(grant), 32'd2);
    chk("t2_ready", 32'(ready_req), 32'h4);
    tick(); chk("t2_b1", 32'(data_out), 32'h23); chk("t2_v1", 32'(valid_out), 32'd1);
    valid_req = 4'b0000;
    tick(); chk("t2_idle", 32'(data_out), 32'(COM)); chk("t2_g2", 32'(grant), 32'd2);
    valid_req = 4'b0100;
    data_req[23:16] = 8'h24;
    #1;
    chk("t2_ready2", 32'(ready_req), 32'h4);
    tick(); chk("t2_b2", 32'(data_out), 32'h24); chk("t2_v2", 32'(valid_out), 32'd1);
    valid_req = 4'b0000;
    tick(); chk("t2_end", 32'(valid_out), 32'd0); chk("t2_link", 32'(link_up), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
